// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_emulator
//  Purpose  : Emulates one key of a 4x4 active-low matrix keypad, including
//             contact bounce, steady hold, release bounce and a quiet gap.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_emulator #(
    parameter int HOLD_W     = 16,
    parameter int BOUNCE_CYC = 8,
    parameter int GAP_CYC    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_key,
    input  logic [HOLD_W-1:0] req_hold,
    input  logic              abort,
    input  logic [3:0]        row,
    output logic [3:0]        col,
    output logic              pressed,
    output logic              busy,
    output logic              done
);

    localparam int B_W   = (BOUNCE_CYC > 0) ? $clog2(BOUNCE_CYC + 1) : 1;
    localparam int G_W   = $clog2(GAP_CYC + 1);
    localparam int BG_W  = (B_W > G_W) ? B_W : G_W;
    localparam int CNT_W = (HOLD_W > BG_W) ? HOLD_W : BG_W;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_BOUNCE_IN  = 3'd1;
    localparam logic [2:0] S_HOLD       = 3'd2;
    localparam logic [2:0] S_BOUNCE_OUT = 3'd3;
    localparam logic [2:0] S_GAP        = 3'd4;

    localparam bit               C_HAS_BOUNCE  = (BOUNCE_CYC > 0);
    localparam logic [CNT_W-1:0] C_BOUNCE_LOAD = CNT_W'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] C_GAP_LOAD    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_key;
    logic [HOLD_W-1:0] r_hold;
    logic              r_contact;
    logic              r_done;

    logic              w_accept;
    logic              w_cnt_zero;
    logic [CNT_W-1:0]  w_req_hold_load;
    logic [CNT_W-1:0]  w_hold_load;
    logic [CNT_W-1:0]  w_cnt_dec;

    // Ready stays low during the done cycle so a new press never overlaps it.
    assign req_ready       = (r_state == S_IDLE) && !r_done;
    assign w_accept        = req_valid && req_ready;
    assign w_cnt_zero      = (r_cnt == '0);
    assign w_cnt_dec       = r_cnt - C_ONE;
    assign w_req_hold_load = CNT_W'(req_hold) - C_ONE;
    assign w_hold_load     = CNT_W'(r_hold) - C_ONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_key     <= '0;
            r_hold    <= '0;
            r_contact <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_contact <= 1'b0;
                    if (w_accept) begin
                        r_key  <= req_key;
                        r_hold <= req_hold;
                        if (req_hold == '0) begin
                            r_state <= S_GAP;
                            r_cnt   <= C_GAP_LOAD;
                        end else if (C_HAS_BOUNCE) begin
                            r_state   <= S_BOUNCE_IN;
                            r_cnt     <= C_BOUNCE_LOAD;
                            r_contact <= 1'b1;
                        end else begin
                            r_state   <= S_HOLD;
                            r_cnt     <= w_req_hold_load;
                            r_contact <= 1'b1;
                        end
                    end
                end
                S_BOUNCE_IN: begin
                    if (abort) begin
                        r_state   <= S_GAP;
                        r_cnt     <= C_GAP_LOAD;
                        r_contact <= 1'b0;
                    end else if (w_cnt_zero) begin
                        r_state   <= S_HOLD;
                        r_cnt     <= w_hold_load;
                        r_contact <= 1'b1;
                    end else begin
                        r_cnt     <= w_cnt_dec;
                        r_contact <= ~r_contact;
                    end
                end
                S_HOLD: begin
                    if (abort || (w_cnt_zero && !C_HAS_BOUNCE)) begin
                        r_state   <= S_GAP;
                        r_cnt     <= C_GAP_LOAD;
                        r_contact <= 1'b0;
                    end else if (w_cnt_zero) begin
                        r_state   <= S_BOUNCE_OUT;
                        r_cnt     <= C_BOUNCE_LOAD;
                        r_contact <= 1'b0;
                    end else begin
                        r_cnt     <= w_cnt_dec;
                        r_contact <= 1'b1;
                    end
                end
                S_BOUNCE_OUT: begin
                    if (abort || w_cnt_zero) begin
                        r_state   <= S_GAP;
                        r_cnt     <= C_GAP_LOAD;
                        r_contact <= 1'b0;
                    end else begin
                        r_cnt     <= w_cnt_dec;
                        r_contact <= ~r_contact;
                    end
                end
                S_GAP: begin
                    r_contact <= 1'b0;
                    if (w_cnt_zero) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_contact <= 1'b0;
                end
            endcase
        end
    end

    // Behaves like a passive switch: the column follows the row strobe instantly.
    assign col     = (r_contact && !row[r_key[3:2]]) ? ~(4'b0001 << r_key[1:0]) : 4'b1111;
    assign pressed = r_contact;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_emulator
//  Purpose  : Self-checking bench for keypad_emulator (bounce and no-bounce).
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_emulator;

    localparam int HW  = 8;
    localparam int G   = 6;
    localparam int B_A = 8;
    localparam int B_B = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [3:0]    req_key;
    logic [HW-1:0] req_hold;
    logic          abort;
    logic [3:0]    row;

    logic       ready_a, pressed_a, busy_a, done_a;
    logic [3:0] col_a;
    logic       ready_b, pressed_b, busy_b, done_b;
    logic [3:0] col_b;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    keypad_emulator #(.HOLD_W(HW), .BOUNCE_CYC(B_A), .GAP_CYC(G)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
        .req_key(req_key), .req_hold(req_hold), .abort(abort), .row(row),
        .col(col_a), .pressed(pressed_a), .busy(busy_a), .done(done_a)
    );

    keypad_emulator #(.HOLD_W(HW), .BOUNCE_CYC(B_B), .GAP_CYC(G)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b),
        .req_key(req_key), .req_hold(req_hold), .abort(abort), .row(row),
        .col(col_b), .pressed(pressed_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: each press is a timeline indexed by cycles since acceptance.
    typedef struct packed {
        logic       pressed;
        logic       busy;
        logic       done;
        logic       ready;
        logic [3:0] col;
    } exp_t;

    bit         m_act [2];
    int         m_k   [2];
    int         m_h   [2];
    int         m_ka  [2];
    logic [3:0] m_key [2];

    function automatic int end_press(input int b, input int h, input int ka);
        if (h == 0)  return 0;
        if (ka != 0) return ka;
        return 2 * b + h;
    endfunction

    function automatic exp_t model_out(input int b, input bit act, input int k, input int h,
                                       input int ka, input logic [3:0] key, input logic [3:0] rw);
        exp_t e;
        int   ep;
        e = '{pressed: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1, col: 4'hF};
        if (act) begin
            ep      = end_press(b, h, ka);
            e.ready = 1'b0;
            e.busy  = (k <= ep + G);
            e.done  = (k == ep + G + 1);
            if (k <= ep) begin
                if (k <= b)          e.pressed = ((k - 1) % 2 == 0);
                else if (k <= b + h) e.pressed = 1'b1;
                else                 e.pressed = ((k - b - h - 1) % 2 == 1);
            end
            if (e.pressed && !rw[key[3:2]]) e.col = ~(4'b0001 << key[1:0]);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int b;
            int ep;
            b = (d == 0) ? B_A : B_B;
            if (!rst_n) begin
                m_act[d] = 1'b0;
            end else if (!m_act[d]) begin
                if (req_valid) begin
                    m_act[d] = 1'b1;
                    m_k[d]   = 1;
                    m_h[d]   = int'(req_hold);
                    m_key[d] = req_key;
                    m_ka[d]  = 0;
                end
            end else begin
                ep = end_press(b, m_h[d], m_ka[d]);
                if (abort && m_ka[d] == 0 && m_h[d] != 0 && m_k[d] <= ep) m_ka[d] = m_k[d];
                if (m_k[d] == ep + G + 1) m_act[d] = 1'b0;
                else                      m_k[d]++;
            end
        end
    end

    always @(negedge clk) begin
        exp_t ea, eb;
        if (chk_en) begin
            ea = model_out(B_A, m_act[0], m_k[0], m_h[0], m_ka[0], m_key[0], row);
            eb = model_out(B_B, m_act[1], m_k[1], m_h[1], m_ka[1], m_key[1], row);
            check("a_col",     32'(col_a),     32'(ea.col));
            check("a_pressed", 32'(pressed_a), 32'(ea.pressed));
            check("a_busy",    32'(busy_a),    32'(ea.busy));
            check("a_done",    32'(done_a),    32'(ea.done));
            check("a_ready",   32'(ready_a),   32'(ea.ready));
            check("b_col",     32'(col_b),     32'(eb.col));
            check("b_pressed", 32'(pressed_b), 32'(eb.pressed));
            check("b_busy",    32'(busy_b),    32'(eb.busy));
            check("b_done",    32'(done_b),    32'(eb.done));
            check("b_ready",   32'(ready_b),   32'(eb.ready));
        end
    end

    typedef struct {
        logic [3:0] key;
        int         hold;
        int         abort_k;
        int         exp_lat;
        int         exp_press;
    } vec_t;

    vec_t vecs [7];

    // One request to the bouncing instance; measures done latency and closed-contact cycles.
    task automatic apply_vec(input vec_t v, input int idx);
        int k, lat, pcnt, guard;
        guard = 0;
        @(negedge clk);
        while (!ready_a && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("v%0d_ready_wait", idx), 32'(ready_a), 32'd1);
        req_valid = 1'b1;
        req_key   = v.key;
        req_hold  = HW'(v.hold);
        abort     = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 1; lat = 0; pcnt = 0;
        while (lat == 0 && k < 600) begin
            abort = (k == v.abort_k);
            @(negedge clk);
            if (pressed_a) pcnt++;
            if (done_a) lat = k;
            @(posedge clk); #1;
            k++;
        end
        abort = 1'b0;
        check($sformatf("v%0d_done_latency", idx), 32'(lat),  32'(v.exp_lat));
        check($sformatf("v%0d_closed_cycles", idx), 32'(pcnt), 32'(v.exp_press));
    endtask

    initial begin
        logic [3:0] rot [4];
        int k, lat, hit, bad, guard, dcnt;

        // key, hold, abort cycle (0 = none), done latency, closed cycles; bounce = 8, gap = 6
        vecs[0] = '{4'hF, 10,  0,  33,  18};
        vecs[1] = '{4'h0, 0,   0,  7,   0};
        vecs[2] = '{4'h6, 1,   0,  24,  9};
        vecs[3] = '{4'h9, 100, 13, 20,  9};
        vecs[4] = '{4'h3, 20,  3,  10,  2};
        vecs[5] = '{4'hC, 255, 0,  278, 263};
        vecs[6] = '{4'hA, 5,   17, 24,  11};
        rot = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        rst_n = 1'b0; req_valid = 1'b0; req_key = '0; req_hold = '0; abort = 1'b0; row = 4'b0000;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_col",     32'(col_a),     32'hF);
        check("reset_pressed", 32'(pressed_a), 32'd0);
        check("reset_busy",    32'(busy_a),    32'd0);
        check("reset_ready",   32'(ready_a),   32'd1);

        for (int i = 0; i < 7; i++) apply_vec(vecs[i], i);

        // No-bounce instance, rotating row strobes.
        guard = 0;
        @(negedge clk);
        while (!ready_b && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_key = 4'b0110; req_hold = HW'(200); row = rot[0];
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 1; lat = 0; hit = 0; bad = 0;
        while (lat == 0 && k < 400) begin
            row = rot[k % 4];
            @(negedge clk);
            if (col_b == 4'b1011) begin
                if (row == 4'b1101) hit++;
                else                bad++;
            end
            if (col_b != 4'b1011 && col_b != 4'b1111) bad++;
            if (done_b) lat = k;
            @(posedge clk); #1;
            k++;
        end
        check("rot_hits",    32'(hit), 32'd50);
        check("rot_bad_col", 32'(bad), 32'd0);
        check("rot_latency", 32'(lat), 32'(200 + G + 1));
        row = 4'b0000;

        // Reset in the middle of HOLD.
        guard = 0;
        @(negedge clk);
        while (!ready_a && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_key = 4'h0; req_hold = HW'(100);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_hold_col", 32'(col_a), 32'hE);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_col",     32'(col_a),     32'hF);
        check("midrst_pressed", 32'(pressed_a), 32'd0);
        check("midrst_busy",    32'(busy_a),    32'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_a) dcnt++;
        end
        check("midrst_no_done", 32'(dcnt), 32'd0);
        @(posedge clk); #1;
        apply_vec('{4'h5, 3, 0, 26, 11}, 7);

        // Randomized traffic on both instances against the timeline model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 3) == 0);
            req_key   = 4'($urandom);
            req_hold  = ($urandom_range(0, 3) == 0) ? HW'(0) : HW'($urandom_range(1, 30));
            abort     = ($urandom_range(0, 19) == 0);
            row       = 4'($urandom);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; abort = 1'b0;
        repeat (150) @(posedge clk);
        @(negedge clk);
        check("drain_idle_a", 32'(busy_a), 32'd0);
        check("drain_idle_b", 32'(busy_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
